// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: MEM-stage load/store bridge onto an APB master port.
// A request is taken in IDLE. A misaligned request goes straight to a
// one-cycle error completion. Otherwise the controller runs one SETUP
// cycle and then one or more ACCESS cycles. ACCESS ends on PREADY or
// when the wait counter reaches TIMEOUT. A one-cycle DONE state reports
// the completion.
//
// Handshake: APB valid/ready. PSEL marks a transfer and PENABLE marks
// its ACCESS phase. The transfer completes on a rising edge where
// PSEL=1, PENABLE=1 and PREADY=1. PADDR, PWRITE, PSTRB and PWDATA stay
// constant from SETUP until that edge.
//
// The FSM state is kept in the signal 'state' (type state_t) so that
// checkers can bind to it.
module apb_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transEnM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemStrobeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        store_done,
  output logic        bus_err,
  output logic [31:0] ReadDataM,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        err_q;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_inc;
  logic        misaligned;
  logic        timeout_hit;
  logic        active;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;

  // Alignment check on the live request, and the saturating wait-count step.
  always_comb begin
    misaligned  = ((MemStrobeM == 2'b01) && ALUResultM[0]) ||
                  (MemStrobeM[1] && (ALUResultM[1:0] != 2'b00));
    cnt_inc     = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    timeout_hit = (cnt_inc >= TIMEOUT_C);
  end

  // State register; reset drops any transfer in flight without a completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transEnM) state_nxt = misaligned ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter, error flag and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      ReadDataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transEnM) begin
            addr_q   <= ALUResultM;
            data_q   <= WriteDataM;
            size_q   <= MemStrobeM;
            write_q  <= MemWriteM;
            err_q    <= misaligned;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            err_q <= PSLVERR;
            if (!write_q) ReadDataM <= PRDATA;
          end else begin
            wait_cnt <= cnt_inc;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-lane steering of the captured store; size 11 is handled as a word.
  always_comb begin
    lane_strb = 4'b1111;
    lane_data = data_q;
    case (size_q)
      2'b00: begin
        lane_strb = 4'b0001 << addr_q[1:0];
        lane_data = {4{data_q[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << addr_q[1:0];
        lane_data = {2{data_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Output decode. The bus is silent outside SETUP/ACCESS, and StallM is
  // forced low while reset is asserted.
  always_comb begin
    active     = (state == SETUP) || (state == ACCESS);
    PSEL       = active;
    PENABLE    = (state == ACCESS);
    PWRITE     = active && write_q;
    PADDR      = active ? {addr_q[31:2], 2'b00} : 32'h0;
    PSTRB      = (active && write_q) ? lane_strb : 4'b0000;
    PWDATA     = (active && write_q) ? lane_data : 32'h0;
    store_done = (state == DONE);
    bus_err    = (state == DONE) && err_q;
    StallM     = rst && (active || ((state == IDLE) && transEnM));
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// tb_apb_mem_ctrl: directed scenarios for apb_mem_ctrl. Expected values
// are worked out by hand. Inputs change 1 ns after the rising edge or on
// the falling edge. Outputs are sampled on the falling edge.
module tb_apb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        transEnM;
  logic        MemWriteM;
  logic [1:0]  MemStrobeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic        store_done;
  logic        bus_err;
  logic [31:0] ReadDataM;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  // Values recorded by do_xfer for the most recent transfer.
  int          obs_stall;
  int          obs_setup;
  int          obs_access;
  int          obs_psel;
  int          obs_first_psel;
  logic        obs_stable;
  logic        obs_done;
  logic        obs_err;
  logic [31:0] obs_paddr;
  logic [31:0] obs_pwdata;
  logic [3:0]  obs_pstrb;
  logic        obs_pwrite;
  logic [31:0] obs_rdata;

  apb_mem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .transEnM(transEnM), .MemWriteM(MemWriteM),
    .MemStrobeM(MemStrobeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .store_done(store_done), .bus_err(bus_err),
    .ReadDataM(ReadDataM), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request from just after a rising edge and hold it
  // until the completion pulse. The slave drives PREADY=1 in the
  // (nwait+1)-th ACCESS cycle. Returns at the falling edge of DONE with
  // transEnM still high.
  task automatic do_xfer(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input int nwait, input logic [31:0] rdata,
                         input logic slverr);
    int acc;
    acc = 0;
    obs_stall = 0; obs_setup = 0; obs_access = 0; obs_psel = 0;
    obs_first_psel = -1; obs_stable = 1'b1; obs_done = 1'b0; obs_err = 1'b0;
    obs_paddr = '0; obs_pwdata = '0; obs_pstrb = '0; obs_pwrite = 1'b0;
    obs_rdata = '0;
    @(posedge clk); #1;
    transEnM = 1'b1; MemWriteM = wr; MemStrobeM = sz;
    ALUResultM = a; WriteDataM = d;
    PRDATA = rdata; PSLVERR = slverr; PREADY = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (StallM) obs_stall++;
      if (PSEL) begin
        if (obs_psel == 0) begin
          obs_first_psel = c;
          obs_paddr = PADDR; obs_pwdata = PWDATA;
          obs_pstrb = PSTRB; obs_pwrite = PWRITE;
        end else if (PADDR !== obs_paddr || PWDATA !== obs_pwdata ||
                     PSTRB !== obs_pstrb || PWRITE !== obs_pwrite) begin
          obs_stable = 1'b0;
        end
        obs_psel++;
        if (PENABLE) begin
          obs_access++;
          acc++;
        end else begin
          obs_setup++;
        end
      end
      PREADY = (PSEL && PENABLE && (acc > nwait));
      if (store_done) begin
        obs_done = 1'b1;
        obs_err  = bus_err;
        obs_rdata = ReadDataM;
        PREADY = 1'b0;
        break;
      end
    end
    if (!obs_done) begin
      checks++; failures++;
      $display("FAIL xfer_timeout_bound: addr=%h no store_done within 300 cycles, required a completion", a);
    end
  endtask

  // Driver: drop the request after the completion cycle.
  task automatic drop_req();
    @(posedge clk); #1;
    transEnM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; transEnM = 1'b0; MemWriteM = 1'b0; MemStrobeM = 2'b00;
    ALUResultM = '0; WriteDataM = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({StallM, store_done, bus_err, PSEL, PENABLE, PWRITE} !== 6'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b done=%b err=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b, required all 0",
               StallM, store_done, bus_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB);
    end
    checks++;
    if (ReadDataM !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h required 00000000", ReadDataM);
    end
    rst = 1'b1;
  endtask

  task automatic test_word_write();
    do_xfer(1'b1, 2'b10, 32'h1000_0004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    checks++;
    if (obs_paddr !== 32'h1000_0004 || obs_pstrb !== 4'b1111 ||
        obs_pwdata !== 32'hDEAD_BEEF || obs_pwrite !== 1'b1) begin
      failures++;
      $display("FAIL word_write_bus: paddr=%h pstrb=%b pwdata=%h pwrite=%b required 10000004 1111 deadbeef 1",
               obs_paddr, obs_pstrb, obs_pwdata, obs_pwrite);
    end
    checks++;
    if (obs_stall != 3 || obs_setup != 1 || obs_access != 1 || obs_first_psel != 1) begin
      failures++;
      $display("FAIL word_write_timing: stall=%0d setup=%0d access=%0d first_psel=%0d required 3 1 1 1",
               obs_stall, obs_setup, obs_access, obs_first_psel);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_stable !== 1'b1) begin
      failures++;
      $display("FAIL word_write_status: err=%b stable=%b required 0 1", obs_err, obs_stable);
    end
    drop_req();
    @(negedge clk);
    checks++;
    if (store_done !== 1'b0 || StallM !== 1'b0 || PSEL !== 1'b0 || PSTRB !== 4'h0 || PWDATA !== 32'h0) begin
      failures++;
      $display("FAIL word_write_after: done=%b stall=%b psel=%b pstrb=%b pwdata=%h required 0 0 0 0000 00000000",
               store_done, StallM, PSEL, PSTRB, PWDATA);
    end
  endtask

  task automatic test_byte_half_write();
    do_xfer(1'b1, 2'b00, 32'h2000_0003, 32'h0000_00A5, 0, 32'h0, 1'b0);
    checks++;
    if (obs_paddr !== 32'h2000_0000 || obs_pstrb !== 4'b1000 || obs_pwdata !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL byte_write: paddr=%h pstrb=%b pwdata=%h required 20000000 1000 a5a5a5a5",
               obs_paddr, obs_pstrb, obs_pwdata);
    end
    drop_req();
    do_xfer(1'b1, 2'b01, 32'h3000_0002, 32'h1234_BEEF, 0, 32'h0, 1'b0);
    checks++;
    if (obs_paddr !== 32'h3000_0000 || obs_pstrb !== 4'b1100 ||
        obs_pwdata !== 32'hBEEF_BEEF || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL half_write: paddr=%h pstrb=%b pwdata=%h err=%b required 30000000 1100 beefbeef 0",
               obs_paddr, obs_pstrb, obs_pwdata, obs_err);
    end
    drop_req();
    do_xfer(1'b1, 2'b11, 32'h4000_0008, 32'h0123_4567, 0, 32'h0, 1'b0);
    checks++;
    if (obs_pstrb !== 4'b1111 || obs_pwdata !== 32'h0123_4567 || obs_paddr !== 32'h4000_0008) begin
      failures++;
      $display("FAIL reserved_size_write: paddr=%h pstrb=%b pwdata=%h required 40000008 1111 01234567",
               obs_paddr, obs_pstrb, obs_pwdata);
    end
    drop_req();
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 2'b10, 32'h5000_0010, 32'hFFFF_FFFF, 4, 32'h1234_5678, 1'b0);
    checks++;
    if (obs_stall != 7 || obs_access != 5) begin
      failures++;
      $display("FAIL read_wait_timing: stall=%0d access=%0d required 7 5", obs_stall, obs_access);
    end
    checks++;
    if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL read_wait_data: rdata=%h err=%b required 12345678 0", obs_rdata, obs_err);
    end
    checks++;
    if (obs_pstrb !== 4'b0000 || obs_pwrite !== 1'b0 || obs_stable !== 1'b1) begin
      failures++;
      $display("FAIL read_wait_bus: pstrb=%b pwrite=%b stable=%b required 0000 0 1",
               obs_pstrb, obs_pwrite, obs_stable);
    end
    drop_req();
  endtask

  task automatic test_misaligned();
    do_xfer(1'b1, 2'b01, 32'h6000_0001, 32'h0000_5555, 0, 32'h0, 1'b0);
    checks++;
    if (obs_psel != 0 || obs_stall != 1 || obs_done !== 1'b1 || obs_err !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_half: psel_cycles=%0d stall=%0d done=%b err=%b required 0 1 1 1",
               obs_psel, obs_stall, obs_done, obs_err);
    end
    drop_req();
    do_xfer(1'b0, 2'b10, 32'h6000_0002, 32'h0, 0, 32'hDDDD_DDDD, 1'b0);
    checks++;
    if (obs_psel != 0 || obs_err !== 1'b1 || obs_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL misaligned_word_read: psel_cycles=%0d err=%b rdata=%h required 0 1 12345678",
               obs_psel, obs_err, obs_rdata);
    end
    drop_req();
  endtask

  task automatic test_slverr();
    do_xfer(1'b1, 2'b10, 32'h7000_0000, 32'hAAAA_5555, 1, 32'h0, 1'b1);
    checks++;
    if (obs_err !== 1'b1 || obs_stall != 4 || obs_access != 2) begin
      failures++;
      $display("FAIL slverr_write: err=%b stall=%0d access=%0d required 1 4 2",
               obs_err, obs_stall, obs_access);
    end
    drop_req();
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 2'b10, 32'h8000_0000, 32'h0, 1000, 32'hCAFE_F00D, 1'b0);
    checks++;
    if (obs_access != 15 || obs_stall != 17 || obs_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout: access=%0d stall=%0d err=%b required 15 17 1",
               obs_access, obs_stall, obs_err);
    end
    checks++;
    if (obs_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL timeout_rdata: got %h required 12345678", obs_rdata);
    end
    drop_req();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 2'b00, 32'h9000_0001, 32'h0000_003C, 0, 32'h0, 1'b0);
    checks++;
    if (obs_pstrb !== 4'b0010 || obs_pwdata !== 32'h3C3C_3C3C) begin
      failures++;
      $display("FAIL b2b_first: pstrb=%b pwdata=%h required 0010 3c3c3c3c", obs_pstrb, obs_pwdata);
    end
    do_xfer(1'b0, 2'b10, 32'h9000_0004, 32'h0, 0, 32'hA1B2_C3D4, 1'b0);
    checks++;
    if (obs_first_psel != 1 || obs_stall != 3 || obs_rdata !== 32'hA1B2_C3D4 ||
        obs_paddr !== 32'h9000_0004) begin
      failures++;
      $display("FAIL b2b_second: first_psel=%0d stall=%0d rdata=%h paddr=%h required 1 3 a1b2c3d4 90000004",
               obs_first_psel, obs_stall, obs_rdata, obs_paddr);
    end
    drop_req();
  endtask

  task automatic test_reset_mid();
    int   seen;
    logic done_seen;
    seen = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    transEnM = 1'b1; MemWriteM = 1'b1; MemStrobeM = 2'b10;
    ALUResultM = 32'hB000_0000; WriteDataM = 32'h1111_2222; PREADY = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (PSEL && PENABLE) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL reset_mid_reach_access: access phase not reached within 10 cycles");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_immediate: psel=%b pen=%b stall=%b rdata=%h required 0 0 0 00000000",
               PSEL, PENABLE, StallM, ReadDataM);
    end
    transEnM = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (store_done) done_seen = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (store_done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done: store_done=%b seen after abort, required 0", done_seen);
    end
    do_xfer(1'b1, 2'b10, 32'hC000_0000, 32'h5A5A_A5A5, 0, 32'h0, 1'b0);
    checks++;
    if (obs_first_psel != 1 || obs_stall != 3 || obs_err !== 1'b0 ||
        obs_pwdata !== 32'h5A5A_A5A5 || obs_paddr !== 32'hC000_0000) begin
      failures++;
      $display("FAIL reset_mid_recover: first_psel=%0d stall=%0d err=%b pwdata=%h paddr=%h required 1 3 0 5a5aa5a5 c0000000",
               obs_first_psel, obs_stall, obs_err, obs_pwdata, obs_paddr);
    end
    drop_req();
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_half_write();
    test_read_wait();
    test_misaligned();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
